// File: rtl/ll_rx_sync_monitor_pkg.sv
// Shared types and constants for the receive-side word-sync monitor.
package ll_rx_sync_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } sync_state_e;

  localparam int LL_LANE_W   = 80;
  localparam int LL_MARKER_W = 4;
  localparam int LL_RX_W     = LL_LANE_W * LL_MARKER_W;

  // Field offsets inside rx_debug_status.
  localparam int DBG_STATE_LSB    = 30;
  localparam int DBG_GOOD_RUN_LSB = 16;
  localparam int DBG_ERR_LSB      = 0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ll_rx_sync_monitor_lane_chk.sv
// Per-lane userbit check: strobe must be 1 and marker must match its expected value.
module ll_rx_sync_lane_chk #(
  parameter int LANE_W  = 80,
  parameter int STB_BIT = 1,
  parameter int MRK_BIT = 79
) (
  input  logic [LANE_W-1:0] lane_data,
  input  logic              mrk_expect,
  output logic              lane_good
);

  logic stb;
  logic mrk;
  logic unused_payload;

  assign stb            = lane_data[STB_BIT];
  assign mrk            = lane_data[MRK_BIT];
  // Payload bits are not inspected here; they only pass through to the concat block.
  assign unused_payload = ^lane_data;
  assign lane_good      = stb & (mrk == mrk_expect);

endmodule

// File: rtl/ll_rx_sync_monitor.sv
// Receive-side word-sync monitor: checks strobe/marker userbits in each PHY word,
// establishes and tracks word lock, and counts bad words seen while locked.
//
// state  | meaning
// IDLE   | rx_online low, nothing checked
// SEARCH | counting consecutive good words toward lock_count
// LOCKED | word sync held; bad words counted toward loss_count
// LOST   | one-cycle loss indication, word not examined
module ll_rx_sync_monitor #(
  parameter int STB_BIT  = 1,
  parameter int MRK_BIT  = 79,
  parameter int LANE_W   = ll_rx_sync_monitor_pkg::LL_LANE_W,
  parameter int MARKER_W = ll_rx_sync_monitor_pkg::LL_MARKER_W
) (
  input  logic                       clk_wr,
  input  logic                       rst_wr_n,
  input  logic                       rx_online,
  input  logic [LANE_W*MARKER_W-1:0] rx_phy0,
  input  logic                       m_gen2_mode,
  input  logic [MARKER_W-1:0]        rx_mrk_expect,
  input  logic [7:0]                 lock_count,
  input  logic [7:0]                 loss_count,
  input  logic                       clear_err,
  output logic                       rx_sync_locked,
  output logic                       rx_sync_lost,
  output logic [15:0]                rx_err_count,
  output logic [31:0]                rx_debug_status
);
  import ll_rx_sync_monitor_pkg::*;

  sync_state_e         state_q, state_d;
  logic [7:0]          good_run_q, good_run_d;
  logic [7:0]          bad_run_q, bad_run_d;
  logic [15:0]         err_q, err_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;

  logic [MARKER_W-1:0] lane_good;
  logic [MARKER_W-1:0] lane_en;
  logic                word_good;
  logic [7:0]          lock_thr;
  logic [7:0]          loss_thr;
  logic [8:0]          good_inc;
  logic [8:0]          bad_inc;

  for (genvar i = 0; i < MARKER_W; i++) begin : g_lane
    ll_rx_sync_lane_chk #(
      .LANE_W (LANE_W),
      .STB_BIT(STB_BIT),
      .MRK_BIT(MRK_BIT)
    ) u_lane_chk (
      .lane_data (rx_phy0[i*LANE_W +: LANE_W]),
      .mrk_expect(rx_mrk_expect[i]),
      .lane_good (lane_good[i])
    );
  end

  // Gen1 only looks at lane 0; unchecked lanes are forced good before the AND.
  assign lane_en   = m_gen2_mode ? {MARKER_W{1'b1}} : MARKER_W'(1);
  assign word_good = &(lane_good | ~lane_en);
  assign lock_thr  = (lock_count == 8'd0) ? 8'd1 : lock_count;
  assign loss_thr  = (loss_count == 8'd0) ? 8'd1 : loss_count;
  // Compare against the unsaturated increment so a threshold of 255 is still reachable.
  assign good_inc  = {1'b0, good_run_q} + 9'd1;
  assign bad_inc   = {1'b0, bad_run_q} + 9'd1;

  // Next-state, run counters and error counter.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    err_d      = err_q;
    if (!rx_online) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SEARCH;
          good_run_d = 8'd0;
          bad_run_d  = 8'd0;
        end
        ST_SEARCH: begin
          if (word_good) begin
            good_run_d = sat_inc8(good_run_q);
            if (good_inc >= {1'b0, lock_thr}) begin
              state_d   = ST_LOCKED;
              bad_run_d = 8'd0;
            end
          end else begin
            good_run_d = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (word_good) begin
            bad_run_d = 8'd0;
          end else begin
            bad_run_d = sat_inc8(bad_run_q);
            err_d     = sat_inc16(err_q);
            if (bad_inc >= {1'b0, loss_thr}) begin
              state_d = ST_LOST;
            end
          end
        end
        ST_LOST: begin
          state_d    = ST_SEARCH;
          good_run_d = 8'd0;
          bad_run_d  = 8'd0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (clear_err) begin
      err_d = 16'd0;
    end
    locked_d = (state_d == ST_LOCKED);
    lost_d   = (state_d == ST_LOST);
  end

  // State and counter registers.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q    <= ST_IDLE;
      good_run_q <= 8'd0;
      bad_run_q  <= 8'd0;
      err_q      <= 16'd0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      lost_q     <= lost_d;
    end
  end

  // Debug word assembly.
  always_comb begin
    rx_debug_status = 32'd0;
    rx_debug_status[DBG_STATE_LSB +: 2]    = state_q;
    rx_debug_status[DBG_GOOD_RUN_LSB +: 8] = good_run_q;
    rx_debug_status[DBG_ERR_LSB +: 16]     = err_q;
  end

  assign rx_sync_locked = locked_q;
  assign rx_sync_lost   = lost_q;
  assign rx_err_count   = err_q;

endmodule

// File: tb/tb_ll_rx_sync_monitor.sv
// Bench for ll_rx_sync_monitor: directed vector table, reset corners, random run
// against a behavioural model, and error-counter saturation/clear.
module tb_ll_rx_sync_monitor;

  localparam int P_IDLE = 0, P_SEARCH = 1, P_LOCKED = 2, P_LOST = 3;

  logic         clk_wr = 1'b0;
  logic         rst_wr_n = 1'b0;
  logic         rx_online = 1'b0;
  logic [319:0] rx_phy0 = '0;
  logic         m_gen2_mode = 1'b1;
  logic [3:0]   rx_mrk_expect = 4'hF;
  logic [7:0]   lock_count = 8'd4;
  logic [7:0]   loss_count = 8'd2;
  logic         clear_err = 1'b0;
  logic         rx_sync_locked;
  logic         rx_sync_lost;
  logic [15:0]  rx_err_count;
  logic [31:0]  rx_debug_status;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // behavioural model
  int m_phase;
  int m_good_run;
  int m_bad_run;
  int m_err;

  ll_rx_sync_monitor dut (
    .clk_wr         (clk_wr),
    .rst_wr_n       (rst_wr_n),
    .rx_online      (rx_online),
    .rx_phy0        (rx_phy0),
    .m_gen2_mode    (m_gen2_mode),
    .rx_mrk_expect  (rx_mrk_expect),
    .lock_count     (lock_count),
    .loss_count     (loss_count),
    .clear_err      (clear_err),
    .rx_sync_locked (rx_sync_locked),
    .rx_sync_lost   (rx_sync_lost),
    .rx_err_count   (rx_err_count),
    .rx_debug_status(rx_debug_status)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic        online;
    logic        gen2;
    logic [3:0]  stb;
    logic [3:0]  mrk;
    logic [3:0]  expv;
    logic [7:0]  lock_c;
    logic [7:0]  loss_c;
    logic        clr;
    logic        e_locked;
    logic        e_lost;
    logic [15:0] e_err;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic on, logic g2, logic [3:0] s, logic [3:0] m,
                              logic el, logic ex, logic [15:0] ee, logic [1:0] es);
    vec_t v;
    v.online = on; v.gen2 = g2; v.stb = s; v.mrk = m; v.expv = 4'hF;
    v.lock_c = 8'd4; v.loss_c = 8'd2; v.clr = 1'b0;
    v.e_locked = el; v.e_lost = ex; v.e_err = ee; v.e_state = es;
    return v;
  endfunction

  function automatic logic [319:0] build_word(logic [3:0] stb, logic [3:0] mrk);
    logic [319:0] w;
    for (int i = 0; i < 10; i++) w[i*32 +: 32] = $urandom;
    for (int l = 0; l < 4; l++) begin
      w[l*80 + 1]  = stb[l];
      w[l*80 + 79] = mrk[l];
    end
    return w;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_phase = P_IDLE; m_good_run = 0; m_bad_run = 0; m_err = 0;
  endfunction

  // Word judged good when every lane in use carries strobe=1 and its expected marker.
  function automatic bit model_good();
    int n = m_gen2_mode ? 4 : 1;
    for (int l = 0; l < n; l++) begin
      if (rx_phy0[l*80 + 1] != 1'b1) return 0;
      if (rx_phy0[l*80 + 79] != rx_mrk_expect[l]) return 0;
    end
    return 1;
  endfunction

  function automatic void model_step();
    int lk = (lock_count == 0) ? 1 : int'(lock_count);
    int ls = (loss_count == 0) ? 1 : int'(loss_count);
    bit g = model_good();
    if (!rx_online) m_phase = P_IDLE;
    else if (m_phase == P_IDLE || m_phase == P_LOST) begin
      m_phase = P_SEARCH; m_good_run = 0; m_bad_run = 0;
    end else if (m_phase == P_SEARCH) begin
      if (g) begin
        if (m_good_run + 1 >= lk) begin m_phase = P_LOCKED; m_bad_run = 0; end
        m_good_run = (m_good_run + 1 > 255) ? 255 : m_good_run + 1;
      end else m_good_run = 0;
    end else begin
      if (g) m_bad_run = 0;
      else begin
        if (m_err < 65535) m_err = m_err + 1;
        if (m_bad_run + 1 >= ls) m_phase = P_LOST;
        m_bad_run = (m_bad_run + 1 > 255) ? 255 : m_bad_run + 1;
      end
    end
    if (clear_err) m_err = 0;
  endfunction

  task automatic tick();
    @(posedge clk_wr);
    model_step();
    #1;
  endtask

  task automatic drive(logic on, logic g2, logic [3:0] s, logic [3:0] m, logic [3:0] e,
                       logic [7:0] lk, logic [7:0] ls, logic clr);
    rx_online = on; m_gen2_mode = g2; rx_phy0 = build_word(s, m);
    rx_mrk_expect = e; lock_count = lk; loss_count = ls; clear_err = clr;
  endtask

  task automatic check_model(string tag);
    check({tag, "_locked"}, 32'(rx_sync_locked), 32'(m_phase == P_LOCKED));
    check({tag, "_lost"},   32'(rx_sync_lost),   32'(m_phase == P_LOST));
    check({tag, "_err"},    32'(rx_err_count),   32'(m_err));
    check({tag, "_state"},  32'(rx_debug_status[31:30]), 32'(m_phase));
  endtask

  initial begin
    int guard;
    model_reset();
    #12;
    check("rst_locked", 32'(rx_sync_locked), 32'd0);
    check("rst_lost",   32'(rx_sync_lost),   32'd0);
    check("rst_err",    32'(rx_err_count),   32'd0);
    check("rst_debug",  rx_debug_status,     32'd0);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;

    // Directed table: lock with a broken run, loss, relock, online drop, gen1.
    vt.push_back(mk(1, 1, 4'hF, 4'hF, 0, 0, 16'd0, 2'd1));
    for (int i = 0; i < 3; i++) vt.push_back(mk(1, 1, 4'hF, 4'hF, 0, 0, 16'd0, 2'd1));
    vt.push_back(mk(1, 1, 4'hF, 4'hB, 0, 0, 16'd0, 2'd1));
    for (int i = 0; i < 3; i++) vt.push_back(mk(1, 1, 4'hF, 4'hF, 0, 0, 16'd0, 2'd1));
    vt.push_back(mk(1, 1, 4'hF, 4'hF, 1, 0, 16'd0, 2'd2));
    vt.push_back(mk(1, 1, 4'hF, 4'hB, 1, 0, 16'd1, 2'd2));
    vt.push_back(mk(1, 1, 4'hF, 4'hF, 1, 0, 16'd1, 2'd2));
    vt.push_back(mk(1, 1, 4'h7, 4'hF, 1, 0, 16'd2, 2'd2));
    vt.push_back(mk(1, 1, 4'hF, 4'h0, 0, 1, 16'd3, 2'd3));
    vt.push_back(mk(1, 1, 4'hF, 4'hF, 0, 0, 16'd3, 2'd1));
    for (int i = 0; i < 3; i++) vt.push_back(mk(1, 1, 4'hF, 4'hF, 0, 0, 16'd3, 2'd1));
    vt.push_back(mk(1, 1, 4'hF, 4'hF, 1, 0, 16'd3, 2'd2));
    vt.push_back(mk(0, 1, 4'hF, 4'hF, 0, 0, 16'd3, 2'd0));
    vt.push_back(mk(0, 0, 4'hF, 4'hF, 0, 0, 16'd3, 2'd0));
    vt.push_back(mk(1, 0, 4'h7, 4'h1, 0, 0, 16'd3, 2'd1));
    for (int i = 0; i < 3; i++) vt.push_back(mk(1, 0, 4'h7, 4'h1, 0, 0, 16'd3, 2'd1));
    vt.push_back(mk(1, 0, 4'h7, 4'h1, 1, 0, 16'd3, 2'd2));
    vt.push_back(mk(1, 0, 4'hE, 4'hF, 1, 0, 16'd4, 2'd2));
    vt.push_back(mk(1, 0, 4'h7, 4'hF, 1, 0, 16'd4, 2'd2));

    foreach (vt[k]) begin
      drive(vt[k].online, vt[k].gen2, vt[k].stb, vt[k].mrk, vt[k].expv,
            vt[k].lock_c, vt[k].loss_c, vt[k].clr);
      tick();
      check($sformatf("vec%0d_locked", k), 32'(rx_sync_locked), 32'(vt[k].e_locked));
      check($sformatf("vec%0d_lost", k),   32'(rx_sync_lost),   32'(vt[k].e_lost));
      check($sformatf("vec%0d_err", k),    32'(rx_err_count),   32'(vt[k].e_err));
      check($sformatf("vec%0d_state", k),  32'(rx_debug_status[31:30]), 32'(vt[k].e_state));
    end

    // Asynchronous reset in the middle of SEARCH, with a nonzero error count.
    drive(0, 1, 4'hF, 4'hF, 4'hF, 8'd4, 8'd2, 0); tick();
    drive(1, 1, 4'hF, 4'hF, 4'hF, 8'd4, 8'd2, 0); tick();
    tick(); tick();
    check("presrch_state", 32'(rx_debug_status[31:30]), 32'd1);
    check("presrch_err", 32'(rx_err_count), 32'd4);
    #2 rst_wr_n = 1'b0;
    #1;
    check("arst_locked", 32'(rx_sync_locked), 32'd0);
    check("arst_lost",   32'(rx_sync_lost),   32'd0);
    check("arst_err",    32'(rx_err_count),   32'd0);
    check("arst_debug",  rx_debug_status,     32'd0);
    model_reset();
    @(negedge clk_wr);
    rst_wr_n = 1'b1;

    // Random run against the model.
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] e, s, m;
      logic g2;
      e  = ($urandom_range(0, 49) == 0) ? 4'($urandom) : rx_mrk_expect;
      g2 = (m_phase == P_IDLE) ? 1'($urandom) : m_gen2_mode;
      if ($urandom_range(0, 99) < 80) begin s = 4'hF; m = e; end
      else begin s = 4'($urandom); m = 4'($urandom); end
      drive($urandom_range(0, 99) < 97, g2, s, m, e,
            8'($urandom_range(0, 6)), 8'($urandom_range(0, 4)),
            $urandom_range(0, 99) < 3);
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    // Saturate the error counter: lock on one word, lose lock after 255 bad words.
    guard = 0;
    while (m_err != 65535 && guard < 80000) begin
      if (m_phase == P_LOCKED) drive(1, 1, 4'h0, 4'h0, 4'hF, 8'd1, 8'd255, 0);
      else drive(1, 1, 4'hF, 4'hF, 4'hF, 8'd1, 8'd255, 0);
      tick();
      guard++;
    end
    check("sat_reached", 32'(guard < 80000), 32'd1);
    check("sat_err", 32'(rx_err_count), 32'hFFFF);
    guard = 0;
    while (m_phase != P_LOCKED && guard < 10) begin
      drive(1, 1, 4'hF, 4'hF, 4'hF, 8'd1, 8'd255, 0);
      tick();
      guard++;
    end
    check("sat_relock", 32'(rx_sync_locked), 32'd1);
    drive(1, 1, 4'hF, 4'h7, 4'hF, 8'd1, 8'd255, 0); tick();
    check("sat_hold", 32'(rx_err_count), 32'hFFFF);
    check("sat_hold_locked", 32'(rx_sync_locked), 32'd1);
    drive(1, 1, 4'hF, 4'h7, 4'hF, 8'd1, 8'd255, 1); tick();
    check("clr_prio", 32'(rx_err_count), 32'd0);
    check_model("final");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
